// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// byte-enable / legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_e;

  // Loads always fetch the full word; the lane is picked on the way back.
  function automatic logic [3:0] calc_be(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (funct3)
        F3_B:    be = 4'b0001 << addr_lo;
        F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic req_ok(input logic       we,
                                  input logic [2:0] funct3,
                                  input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return legal && !misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/half lane out of a memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store responder in front of a word-wide synchronous
// SRAM; rejects illegal and misaligned requests without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CntW = 3;

  lsu_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       load_data;

  load_align u_load_align (
    .word_i   (mem_rdata),
    .addr_lo_i(addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        // ready_q is only ever set while idle, so it alone qualifies the handshake
        if (req_valid && ready_q) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (!req_ok(req_we, req_funct3, req_addr[1:0])) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d   = CntW'(MEM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_en & we_q;
  assign mem_be    = mem_en ? calc_be(we_q, funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr  = addr_q[ADDR_W-1:2];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the load/store control the instruction controller issues: accepts one load/store request at a time from the core.
- Drives a word-wide synchronous data SRAM with byte enables.
- Returns sign/zero-extended load data or a store completion.
- Sits between the datapath (ALU address result, rs2 data, funct3, dmemwe) and data memory. Flags misaligned and illegal accesses instead of touching memory.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- MEM_LAT, 1, SRAM read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store (dmemwe), 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal access; qualified by rsp_valid.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]).
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  SRAM read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (reset=0, asynchronous) clears every output and register to 0 and forces state IDLE.
  - Reset mid-operation drops the pending request; no late rsp_valid or mem_en after release.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; req_ready=0 in all other states.
  - Handshake req_valid&req_ready at cycle T registers we/funct3/addr/wdata.
  - If the request is illegal or misaligned: go to RESP with err=1; no memory access.
  - Otherwise go to ISSUE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- ISSUE (cycle T+1): mem_en=1, mem_we=we, mem_addr from latched addr. mem_en/mem_we/mem_be are 0 in every other state.
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111.
  - Loads: be=1111.
  - Stores go to RESP; loads go to WAIT with the latency counter set to MEM_LAT.
- WAIT: counter decrements each cycle. On the cycle it reaches 1 (cycle T+1+MEM_LAT), capture mem_rdata, then go to RESP.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RESP: rsp_valid=1 for exactly one cycle, registered, then IDLE. There is no response backpressure.
- Response timing:
  - Error: rsp at T+1.
  - Store: rsp at T+2.
  - Load: rsp at T+2+MEM_LAT.
  - Next request is accepted no earlier than the cycle after RESP.
- rsp_rdata/rsp_err hold their value until the next RESP, so each cycle of RESP presents fresh values.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Function computing byte enables.
- One natural sub-module: load_align, purely combinational. Inputs mem word, addr[1:0], funct3; output extended 32-bit value. It is instantiated in the WAIT capture path.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, MEM_LAT=1 -> ISSUE at T+1 with mem_addr=0x40, be=1111; rsp_valid at T+2 with err=0.
- SB addr=0x103 wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; then LB 0x103 -> rsp_rdata=0xFFFFFFA5; LBU 0x103 -> 0x000000A5.
- Memory word 0x80017FFF at 0x200: LH 0x202 -> 0xFFFF8001; LHU 0x200 -> 0x00007FFF. MEM_LAT=3 gives rsp at T+5.
- LW 0x102 and SH 0x101 -> rsp at T+1 with err=1, rdata=0, mem_en never asserted.
- Illegal: load funct3=011 and store funct3=100 -> rsp at T+1 with err=1, no memory access.
- Assert reset during WAIT of an LW -> all outputs 0 immediately; after release no rsp_valid, req_ready=1 the next cycle; a following LW completes normally.
